// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg -- shared types for the ALU.
//   word_t   : operand/result word (WORD_W bits)
//   alu_op_t : 3-bit operation select
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {
      ALU_NOP = 3'b000,
      ALU_ADD = 3'b001,
      ALU_SUB = 3'b010,
      ALU_AND = 3'b011,
      ALU_OR  = 3'b100,
      ALU_XOR = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRA = 3'b111
   } alu_op_t;

endpackage : alu_pkg

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- single-stage, fully pipelined integer ALU.
//
// A combinational next-result function feeds one output register, giving a
// fixed latency of one cycle and a new operation accepted every cycle.
//
// Ports:
//   i_clk       clock, all state updates on the rising edge
//   i_rst       synchronous, active-high reset
//   i_valid     operation presented this cycle is real
//   i_ALUOp     operation select (alu_op_t encoding)
//   i_operand0  first operand (rs1)
//   i_operand1  second operand (rs2 or immediate)
//   o_valid     o_result holds a completed operation
//   o_result    operation result, forced to zero whenever o_valid is 0
//
// Configuration:
//   ALU_SHIFT_EN  defined   -> SLL/SRA implemented
//                 undefined -> no shifter; opcodes 110/111 are unsupported
// -----------------------------------------------------------------------------
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = $bits(word_t)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [2:0]        i_ALUOp,
   input  logic [DATA_W-1:0] i_operand0,
   input  logic [DATA_W-1:0] i_operand1,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_result
);

   logic              next_valid;
   logic [DATA_W-1:0] next_result;

`ifdef ALU_SHIFT_EN
   // Only the low bits of operand1 select the shift; upper bits are ignored.
   logic [$clog2(DATA_W)-1:0] shamt;
   assign shamt = i_operand1[$clog2(DATA_W)-1:0];
`endif

   // Next-result function. Anything that is not a real, supported operation
   // yields valid=0 and result=0 so the register never holds stale data.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a value unassigned (no latch).
      next_valid  = 1'b0;
      next_result = '0;
      if (i_valid) begin
         next_valid = 1'b1;
         case (alu_op_t'(i_ALUOp))
            // Add/subtract wrap naturally at DATA_W bits; carry is dropped.
            ALU_ADD: next_result = i_operand0 + i_operand1;
            ALU_SUB: next_result = i_operand0 - i_operand1;
            ALU_AND: next_result = i_operand0 & i_operand1;
            ALU_OR:  next_result = i_operand0 | i_operand1;
            ALU_XOR: next_result = i_operand0 ^ i_operand1;
`ifdef ALU_SHIFT_EN
            ALU_SLL: next_result = i_operand0 << shamt;
            // Only SRA interprets operand0 as signed, to replicate the MSB.
            ALU_SRA: next_result = DATA_W'($signed(i_operand0) >>> shamt);
`endif
            default: next_valid = 1'b0;
         endcase
      end
   end

   // Output register stage; reset drops whatever was presented this cycle.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its inputs from before the edge.
      if (i_rst) begin
         o_valid  <= 1'b0;
         o_result <= '0;
      end else begin
         o_valid  <= next_valid;
         o_result <= next_result;
      end
   end

endmodule : alu

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu (DATA_W = 32).
// Directed cases for the documented examples and boundaries, then a
// randomized stream compared against a behavioural reference model.
// Honours ALU_SHIFT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_alu;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic [2:0]  i_ALUOp;
   logic [31:0] i_operand0;
   logic [31:0] i_operand1;
   logic        o_valid;
   logic [31:0] o_result;

   int n_checks = 0;
   int n_passed = 0;

   alu #(.DATA_W(32)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_valid    (i_valid),
      .i_ALUOp    (i_ALUOp),
      .i_operand0 (i_operand0),
      .i_operand1 (i_operand1),
      .o_valid    (o_valid),
      .o_result   (o_result)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference model: returns {valid, result} for one operation, straight
   // from the opcode table.
   function automatic logic [32:0] model(input logic v, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      logic [31:0] fill;
      sh = b % 32;
      if (!v) return 33'd0;
      case (op)
         3'd1: return {1'b1, a + b};
         3'd2: return {1'b1, a - b};
         3'd3: return {1'b1, a & b};
         3'd4: return {1'b1, a | b};
         3'd5: return {1'b1, a ^ b};
`ifdef ALU_SHIFT_EN
         3'd6: return {1'b1, a << sh};
         3'd7: begin
            // Logical shift, then fill vacated top bits with copies of the sign.
            fill = (sh == 0) ? 32'd0 : ~(32'hFFFF_FFFF >> sh);
            return {1'b1, (a >> sh) | (a[31] ? fill : 32'd0)};
         end
`endif
         default: return 33'd0;
      endcase
   endfunction

   // Present one operation for one cycle and check the registered output.
   task automatic step(input string tag, input logic rst, input logic v,
                       input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] exp;
      @(negedge i_clk);
      i_rst = rst; i_valid = v; i_ALUOp = op; i_operand0 = a; i_operand1 = b;
      exp = rst ? 33'd0 : model(v, op, a, b);
      @(posedge i_clk);
      #1;
      check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, exp[32]});
      check({tag, ".result"}, o_result, exp[31:0]);
   endtask

   // Directed check against a literal expected result.
   task automatic step_exp(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic ev, input logic [31:0] er);
      @(negedge i_clk);
      i_rst = 1'b0; i_valid = 1'b1; i_ALUOp = op; i_operand0 = a; i_operand1 = b;
      @(posedge i_clk);
      #1;
      check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, ev});
      check({tag, ".result"}, o_result, er);
   endtask

   initial begin
      i_rst = 1'b1; i_valid = 1'b1; i_ALUOp = 3'd1;
      i_operand0 = 32'd1; i_operand1 = 32'd2;

      // Reset with a valid op presented: op is dropped.
      step("reset0", 1'b1, 1'b1, 3'd1, 32'd1, 32'd2);
      step("reset1", 1'b1, 1'b1, 3'd5, 32'hFFFF_FFFF, 32'd1);

      // First op after reset completes in one cycle.
      step_exp("add_5_7",   3'd1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'h0000_000C);
      step_exp("add_wrap",  3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000);
      step_exp("sub_3_5",   3'd2, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE);
      step_exp("and",       3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000);
      step_exp("or",        3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hFFF0_FFF0);
      step_exp("xor",       3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'h0FF0_0FF0);
      step_exp("nop",       3'd0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0000_0000);
`ifdef ALU_SHIFT_EN
      step_exp("sll_31",    3'd6, 32'h0000_0001, 32'd31,        1'b1, 32'h8000_0000);
      step_exp("sra_4",     3'd7, 32'h8000_0000, 32'd4,         1'b1, 32'hF800_0000);
      step_exp("sra_0x24",  3'd7, 32'h8000_0000, 32'h0000_0024, 1'b1, 32'hF800_0000);
      step_exp("sra_0",     3'd7, 32'h8765_4321, 32'h0000_0020, 1'b1, 32'h8765_4321);
      step_exp("sra_pos",   3'd7, 32'h7000_0000, 32'd28,        1'b1, 32'h0000_0007);
`else
      step_exp("sll_off",   3'd6, 32'h0000_0001, 32'd31,        1'b0, 32'h0000_0000);
      step_exp("sra_off",   3'd7, 32'h8000_0000, 32'd4,         1'b0, 32'h0000_0000);
`endif

      // i_valid=0 with ADD: nothing completes.
      step("invalid_add", 1'b0, 1'b0, 3'd1, 32'd5, 32'd7);

      // Four different ops streamed back to back, reset mid-stream, restart.
      step("stream0", 1'b0, 1'b1, 3'd1, 32'h0000_1000, 32'h0000_0234);
      step("stream1", 1'b0, 1'b1, 3'd2, 32'h0000_0010, 32'h0000_0020);
      step("stream2", 1'b0, 1'b1, 3'd5, 32'hAAAA_5555, 32'hFFFF_0000);
      step("stream3", 1'b0, 1'b1, 3'd3, 32'h0F0F_0F0F, 32'h00FF_00FF);
      step("mid_rst", 1'b1, 1'b1, 3'd4, 32'h1234_0000, 32'h0000_5678);
      step("post_rst", 1'b0, 1'b1, 3'd4, 32'h1234_0000, 32'h0000_5678);

      // Randomized stream including occasional reset, idle and NOP cycles.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a, b;
         a = $urandom();
         b = $urandom();
         if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
         if ($urandom_range(0, 7) == 0) b = 32'h8000_0000 | $urandom_range(0, 63);
         step("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
              3'($urandom_range(0, 7)), a, b);
      end

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule : tb_alu
